// File: rtl/muldiv_unit_pkg.sv
// rtl/muldiv_unit_pkg.sv - shared op codes, FSM states and decode helpers for muldiv_unit
package muldiv_unit_pkg;

  localparam int MD_DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  function automatic logic op_is_mul(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

  function automatic logic op_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// rtl/muldiv_unit_div_core.sv - unsigned iterative restoring divider, one quotient bit per step
// The dividend register shifts out its MSB into the partial remainder while quotient bits shift in.
module muldiv_unit_div_core
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   partial;
  logic             fits;

  always_comb begin
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    partial = {rem_q, quo_q[WIDTH-1]};
    fits    = (partial >= {1'b0, dvs_q});
    if (init) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
      if (fits) begin
        rem_d = WIDTH'(partial - {1'b0, dvs_q});
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = WIDTH'(partial);
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle HI/LO unit for MULT/MULTU/DIV/DIVU producing {hi,lo}
// Owns the FSM, the single-stage product, operand sign handling and result muxing.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MD_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic               flush,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH) + 1;

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               fin_q, fin_d;
  logic [2*WIDTH-1:0] result_q, result_d;

  md_op_e             op_in;
  logic               in_signed;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic               accept;

  logic               div_init, div_step;
  logic [WIDTH-1:0]   div_quo, div_rem;

  logic               mul_sgn;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;

  logic               div_sgn, div_neg, div_by_zero;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign op_in     = md_op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign a_abs     = (in_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (in_signed && b[WIDTH-1]) ? -b : b;
  assign accept    = start && !flush && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  // Sign-extending to 2*WIDTH lets one multiplier serve both signed and unsigned ops.
  assign mul_sgn = op_is_signed(op_q);
  assign mul_a   = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
  assign mul_b   = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
  assign prod    = mul_a * mul_b;

  assign div_sgn     = (op_q == MD_DIV);
  assign div_neg     = div_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign div_by_zero = (b_q == '0);
  assign quo_fix     = div_by_zero ? '1 : (div_neg ? -div_quo : div_quo);
  assign rem_fix     = div_by_zero ? a_q :
                       ((div_sgn && a_q[WIDTH-1]) ? -div_rem : div_rem);

  muldiv_unit_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .clk      (clk),
    .rst      (rst),
    .init     (div_init),
    .step     (div_step),
    .dividend (a_abs),
    .divisor  (b_abs),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    result_d = result_q;
    div_init = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          case (op_in)
            MD_MULT, MD_MULTU: begin
              state_d = ST_MUL;
              op_d    = op_in;
              a_d     = a;
              b_d     = b;
            end
            MD_DIV, MD_DIVU: begin
              state_d  = ST_DIV;
              op_d     = op_in;
              a_d      = a;
              b_d      = b;
              cnt_d    = CW'(WIDTH - 1);
              fin_d    = 1'b0;
              div_init = 1'b1;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end
      ST_MUL: begin
        result_d = prod;
        state_d  = ST_DONE;
      end
      ST_DIV: begin
        // After the last quotient bit, one extra cycle applies sign fix-up into the result.
        if (!fin_q) begin
          div_step = 1'b1;
          if (cnt_q == '0) fin_d = 1'b1;
          else             cnt_d = cnt_q - CW'(1);
        end else begin
          result_d = {rem_fix, quo_fix};
          fin_d    = 1'b0;
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      result_d = result_q;
      fin_d    = 1'b0;
      div_init = 1'b0;
      div_step = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MULT;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      result_q <= result_d;
    end
  end

  assign busy   = (start && ((state_q == ST_IDLE) || (state_q == ST_DONE))) ||
                  (state_q == ST_MUL) || (state_q == ST_DIV);
  assign valid  = (state_q == ST_DONE);
  assign result = result_q;

endmodule
